// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit scheduler.
//   pkt_type_t    : packet type code presented to the bit-stream encoder
//   sched_state_t : scheduler FSM states
//   OWN_*         : bit positions of each source in one-hot owner/grant vectors
//   HS_W/TOK_W/DAT_W : payload widths of the handshake, token and data sources
package usb_tx_pkg;

  localparam int HS_W  = 8;
  localparam int TOK_W = 24;
  localparam int DAT_W = 88;

  // One-hot source positions: {dat, tok, hs}
  localparam int OWN_HS  = 0;
  localparam int OWN_TOK = 1;
  localparam int OWN_DAT = 2;

  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_DATA   = 2'b01,
    PKT_TOKEN  = 2'b10,
    PKT_HSHAKE = 2'b11
  } pkt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // Encoder packet type for a one-hot owner vector.
  function automatic pkt_type_t owner_type(input logic [2:0] own);
    pkt_type_t t;
    t = PKT_NONE;
    if (own[OWN_HS])  t = PKT_HSHAKE;
    if (own[OWN_TOK]) t = PKT_TOKEN;
    if (own[OWN_DAT]) t = PKT_DATA;
    return t;
  endfunction

endpackage

// File: rtl/usb_tx_prio_arb.sv
// Fixed-priority picker (hs > tok > dat) with a starvation guard for data.
//   clk, rst     : clock, synchronous active-high reset
//   req_i[2:0]   : requests {dat, tok, hs}
//   upd_i        : strobe (one per completed packet) to update the skip count
//   owner_dat_i  : the completed packet belonged to the data source
//   dat_wait_i   : data request is pending at the update strobe
//   win_o[2:0]   : one-hot winner {dat, tok, hs}, zero when no request
module usb_tx_prio_arb
  import usb_tx_pkg::*;
#(
  parameter int MAX_SKIP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_i,
  input  logic       upd_i,
  input  logic       owner_dat_i,
  input  logic       dat_wait_i,
  output logic [2:0] win_o
);

  localparam int SKIP_W = $clog2(MAX_SKIP + 1);

  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              starved;

  // Data has been passed over MAX_SKIP times in a row: it jumps the queue.
  assign starved = (skip_q == SKIP_W'(MAX_SKIP));

  always_comb begin
    win_o = 3'b000;
    if (req_i[OWN_DAT] && starved) win_o[OWN_DAT] = 1'b1;
    else if (req_i[OWN_HS])        win_o[OWN_HS]  = 1'b1;
    else if (req_i[OWN_TOK])       win_o[OWN_TOK] = 1'b1;
    else if (req_i[OWN_DAT])       win_o[OWN_DAT] = 1'b1;
  end

  always_comb begin
    skip_d = skip_q;
    if (upd_i) begin
      if (owner_dat_i)              skip_d = '0;
      else if (dat_wait_i && !starved) skip_d = skip_q + SKIP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake/token/data sources onto the single bit-stream encoder,
// tracks each packet until the line driver reports it sent or a watchdog
// expires, and returns a completion pulse with error status to the owner.
//   clk, rst                 : clock, synchronous active-high reset
//   hs/tok/dat_req, *_pld    : source requests and payloads
//   hs/tok/dat_gnt           : one-cycle grant (ISSUE cycle)
//   hs/tok/dat_done, tx_err  : one-cycle completion, tx_err=1 on watchdog abort
//   enc_free, pkt_sent       : encoder ready, end-of-packet pulse from driver
//   pkt_type, data/token/hshake : encoder strobe and latched payloads
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2048,
  parameter int MAX_SKIP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_req,
  input  logic [HS_W-1:0]  hs_pld,
  output logic             hs_gnt,
  output logic             hs_done,
  input  logic             tok_req,
  input  logic [TOK_W-1:0] tok_pld,
  output logic             tok_gnt,
  output logic             tok_done,
  input  logic             dat_req,
  input  logic [DAT_W-1:0] dat_pld,
  output logic             dat_gnt,
  output logic             dat_done,
  output logic             tx_err,
  input  logic             enc_free,
  input  logic             pkt_sent,
  output logic [1:0]       pkt_type,
  output logic [DAT_W-1:0] data,
  output logic [TOK_W-1:0] token,
  output logic [HS_W-1:0]  hshake
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  sched_state_t     state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       done_q, done_d;
  logic             tx_err_q, tx_err_d;
  pkt_type_t        pkt_type_q, pkt_type_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [DAT_W-1:0] data_q, data_d;
  logic [TOK_W-1:0] token_q, token_d;
  logic [HS_W-1:0]  hshake_q, hshake_d;
  logic [2:0]       win;
  logic             skip_upd;

  usb_tx_prio_arb #(.MAX_SKIP(MAX_SKIP)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({dat_req, tok_req, hs_req}),
    .upd_i       (skip_upd),
    .owner_dat_i (owner_q[OWN_DAT]),
    .dat_wait_i  (dat_req),
    .win_o       (win)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wdog_d     = wdog_q;
    gnt_d      = 3'b000;
    done_d     = 3'b000;
    tx_err_d   = 1'b0;
    pkt_type_d = PKT_NONE;
    data_d     = data_q;
    token_d    = token_q;
    hshake_d   = hshake_q;
    skip_upd   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Grant, strobe and payload are registered here so they all appear
        // together during the ISSUE cycle.
        if (enc_free && (win != 3'b000)) begin
          owner_d    = win;
          gnt_d      = win;
          pkt_type_d = owner_type(win);
          if (win[OWN_HS])  hshake_d = hs_pld;
          if (win[OWN_TOK]) token_d  = tok_pld;
          if (win[OWN_DAT]) data_d   = dat_pld;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        wdog_d = wdog_q + WD_W'(1);
        // pkt_sent is checked first so it beats a simultaneous expiry.
        if (pkt_sent) begin
          done_d  = owner_q;
          state_d = ST_DONE;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          done_d   = owner_q;
          tx_err_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        skip_upd = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 3'b000;
      wdog_q     <= '0;
      gnt_q      <= 3'b000;
      done_q     <= 3'b000;
      tx_err_q   <= 1'b0;
      pkt_type_q <= PKT_NONE;
      data_q     <= '0;
      token_q    <= '0;
      hshake_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wdog_q     <= wdog_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_err_q   <= tx_err_d;
      pkt_type_q <= pkt_type_d;
      data_q     <= data_d;
      token_q    <= token_d;
      hshake_q   <= hshake_d;
    end
  end

  assign hs_gnt   = gnt_q[OWN_HS];
  assign tok_gnt  = gnt_q[OWN_TOK];
  assign dat_gnt  = gnt_q[OWN_DAT];
  assign hs_done  = done_q[OWN_HS];
  assign tok_done = done_q[OWN_TOK];
  assign dat_done = done_q[OWN_DAT];
  assign tx_err   = tx_err_q;
  assign pkt_type = pkt_type_q;
  assign data     = data_q;
  assign token    = token_q;
  assign hshake   = hshake_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed testbench for usb_tx_scheduler. u_dut uses the default watchdog;
// u_wd shares the same inputs with TIMEOUT_CYC=16 for the watchdog scenarios.
module tb_usb_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, hs_req, tok_req, dat_req, enc_free, pkt_sent;
  logic [7:0]  hs_pld;
  logic [23:0] tok_pld;
  logic [87:0] dat_pld;

  logic        hs_gnt, hs_done, tok_gnt, tok_done, dat_gnt, dat_done, tx_err;
  logic [1:0]  pkt_type;
  logic [87:0] data;
  logic [23:0] token;
  logic [7:0]  hshake;

  logic        w_hs_gnt, w_hs_done, w_tok_gnt, w_tok_done, w_dat_gnt, w_dat_done, w_tx_err;
  logic [1:0]  w_pkt_type;
  logic [87:0] w_data;
  logic [23:0] w_token;
  logic [7:0]  w_hshake;

  logic [2:0]  gnt_v, done_v;
  assign gnt_v  = {dat_gnt, tok_gnt, hs_gnt};
  assign done_v = {dat_done, tok_done, hs_done};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usb_tx_scheduler u_dut (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_pld(hs_pld), .hs_gnt(hs_gnt), .hs_done(hs_done),
    .tok_req(tok_req), .tok_pld(tok_pld), .tok_gnt(tok_gnt), .tok_done(tok_done),
    .dat_req(dat_req), .dat_pld(dat_pld), .dat_gnt(dat_gnt), .dat_done(dat_done),
    .tx_err(tx_err), .enc_free(enc_free), .pkt_sent(pkt_sent),
    .pkt_type(pkt_type), .data(data), .token(token), .hshake(hshake)
  );

  usb_tx_scheduler #(.TIMEOUT_CYC(16), .MAX_SKIP(4)) u_wd (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_pld(hs_pld), .hs_gnt(w_hs_gnt), .hs_done(w_hs_done),
    .tok_req(tok_req), .tok_pld(tok_pld), .tok_gnt(w_tok_gnt), .tok_done(w_tok_done),
    .dat_req(dat_req), .dat_pld(dat_pld), .dat_gnt(w_dat_gnt), .dat_done(w_dat_done),
    .tx_err(w_tx_err), .enc_free(enc_free), .pkt_sent(pkt_sent),
    .pkt_type(w_pkt_type), .data(w_data), .token(w_token), .hshake(w_hshake)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; hs_req = 1'b0; tok_req = 1'b0; dat_req = 1'b0;
    enc_free = 1'b1; pkt_sent = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hs_req = 1'b1; tok_req = 1'b1; dat_req = 1'b1; enc_free = 1'b1;
    pkt_sent = 1'b1; hs_pld = 8'hFF; tok_pld = 24'hFFFFFF; dat_pld = '1;
    tick(); tick(); tick();
    n_chk++;
    if ({gnt_v, done_v, tx_err, pkt_type} !== 9'd0 || data !== 88'd0 || token !== 24'd0 || hshake !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b type=%b data=%h token=%h hs=%h, required all 0",
               gnt_v, done_v, tx_err, pkt_type, data, token, hshake);
    end
    n_chk++;
    if ({w_hs_gnt, w_tok_gnt, w_dat_gnt, w_hs_done, w_tok_done, w_dat_done, w_tx_err, w_pkt_type} !== 9'd0 ||
        w_data !== 88'd0 || w_token !== 24'd0 || w_hshake !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_wd: some output nonzero, type=%b data=%h token=%h hs=%h, required all 0",
               w_pkt_type, w_data, w_token, w_hshake);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_token();
    logic seen;
    do_reset();
    tok_pld = 24'hA5C3E1; tok_req = 1'b1;
    tick(); // ISSUE
    n_chk++;
    if (gnt_v !== 3'b010 || pkt_type !== 2'b10 || token !== 24'hA5C3E1) begin
      n_fail++;
      $display("FAIL tok_issue: gnt=%b type=%b token=%h, required 010 10 a5c3e1", gnt_v, pkt_type, token);
    end
    tok_req = 1'b0; pkt_sent = 1'b1; // pkt_sent during ISSUE must be ignored
    tick(); // BUSY
    pkt_sent = 1'b0;
    n_chk++;
    if (gnt_v !== 3'b000 || pkt_type !== 2'b00 || done_v !== 3'b000) begin
      n_fail++;
      $display("FAIL tok_busy: gnt=%b type=%b done=%b, required 000 00 000", gnt_v, pkt_type, done_v);
    end
    seen = 1'b0;
    for (int i = 3; i <= 41; i++) begin
      tick();
      if (done_v !== 3'b000) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL tok_early_done: done seen before pkt_sent=%b, required 0", seen);
    end
    pkt_sent = 1'b1; // 40 cycles after ISSUE
    tick();
    pkt_sent = 1'b0;
    n_chk++;
    if (done_v !== 3'b010 || tx_err !== 1'b0 || token !== 24'hA5C3E1) begin
      n_fail++;
      $display("FAIL tok_done: done=%b err=%b token=%h, required 010 0 a5c3e1", done_v, tx_err, token);
    end
    tick();
    n_chk++;
    if (done_v !== 3'b000 || tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tok_done_pulse: done=%b err=%b, required 000 0", done_v, tx_err);
    end
    $display("test_single_token done");
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_g [3];
    logic [1:0] exp_t [3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_t[0] = 2'b11;  exp_t[1] = 2'b10;  exp_t[2] = 2'b01;
    do_reset();
    hs_pld = 8'hD2; tok_pld = 24'h123456; dat_pld = 88'h0123456789ABCDEF001122;
    hs_req = 1'b1; tok_req = 1'b1; dat_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); // ISSUE
      n_chk++;
      if (gnt_v !== exp_g[k] || pkt_type !== exp_t[k]) begin
        n_fail++;
        $display("FAIL sim_issue%0d: gnt=%b type=%b, required %b %b", k, gnt_v, pkt_type, exp_g[k], exp_t[k]);
      end
      if (k == 0) hs_req = 1'b0;
      if (k == 1) tok_req = 1'b0;
      if (k == 2) dat_req = 1'b0;
      tick(); // BUSY
      pkt_sent = 1'b1;
      tick(); // DONE
      pkt_sent = 1'b0;
      n_chk++;
      if (done_v !== exp_g[k] || tx_err !== 1'b0) begin
        n_fail++;
        $display("FAIL sim_done%0d: done=%b err=%b, required %b 0", k, done_v, tx_err, exp_g[k]);
      end
      tick(); // IDLE
      n_chk++;
      if (gnt_v !== 3'b000) begin
        n_fail++;
        $display("FAIL sim_idle%0d: gnt=%b, required 000", k, gnt_v);
      end
    end
    n_chk++;
    if (hshake !== 8'hD2 || token !== 24'h123456 || data !== 88'h0123456789ABCDEF001122) begin
      n_fail++;
      $display("FAIL sim_payload_hold: hs=%h token=%h data=%h, required d2 123456 0123456789abcdef001122",
               hshake, token, data);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_starvation();
    logic [2:0] eg;
    do_reset();
    tok_pld = 24'h0F0F0F; dat_pld = 88'hCAFE;
    tok_req = 1'b1; dat_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      eg = (g == 4) ? 3'b100 : 3'b010;
      tick(); // ISSUE
      n_chk++;
      if (gnt_v !== eg) begin
        n_fail++;
        $display("FAIL starve_gnt%0d: gnt=%b, required %b", g, gnt_v, eg);
      end
      if (eg[2]) dat_req = 1'b0; else tok_req = 1'b0;
      tick(); // BUSY
      pkt_sent = 1'b1;
      tick(); // DONE
      pkt_sent = 1'b0;
      n_chk++;
      if (done_v !== eg) begin
        n_fail++;
        $display("FAIL starve_done%0d: done=%b, required %b", g, done_v, eg);
      end
      if (eg[2]) dat_req = 1'b1; else tok_req = 1'b1;
      tick(); // IDLE
    end
    tok_req = 1'b0; dat_req = 1'b0;
    $display("test_starvation done");
  endtask

  task automatic test_watchdog();
    logic seen;
    do_reset();
    hs_pld = 8'h5A; hs_req = 1'b1;
    tick(); // ISSUE
    n_chk++;
    if (w_hs_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_gnt: hs_gnt=%b, required 1", w_hs_gnt);
    end
    hs_req = 1'b0;
    seen = 1'b0;
    for (int i = 2; i <= 17; i++) begin // 16 BUSY cycles
      tick();
      if (w_hs_done !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_early: done during BUSY=%b, required 0", seen);
    end
    tick();
    n_chk++;
    if (w_hs_done !== 1'b1 || w_tx_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_expire: hs_done=%b tx_err=%b, required 1 1", w_hs_done, w_tx_err);
    end
    tok_req = 1'b1;
    tick(); // IDLE
    n_chk++;
    if (w_hs_done !== 1'b0 || w_tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_err_clear: hs_done=%b tx_err=%b, required 0 0", w_hs_done, w_tx_err);
    end
    tick(); // ISSUE
    n_chk++;
    if (w_tok_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_next_gnt: tok_gnt=%b, required 1", w_tok_gnt);
    end
    tok_req = 1'b0;
    tick(); // BUSY
    pkt_sent = 1'b1;
    tick(); // DONE
    pkt_sent = 1'b0;
    n_chk++;
    if (w_tok_done !== 1'b1 || w_tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_next_done: tok_done=%b tx_err=%b, required 1 0", w_tok_done, w_tx_err);
    end
    $display("test_watchdog done");
  endtask

  task automatic test_sent_at_expiry();
    do_reset();
    hs_pld = 8'h3C; hs_req = 1'b1;
    tick(); // ISSUE
    hs_req = 1'b0;
    for (int i = 2; i <= 17; i++) tick();
    pkt_sent = 1'b1; // sampled together with the last watchdog count
    tick();
    pkt_sent = 1'b0;
    n_chk++;
    if (w_hs_done !== 1'b1 || w_tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sent_at_expiry: hs_done=%b tx_err=%b, required 1 0", w_hs_done, w_tx_err);
    end
    $display("test_sent_at_expiry done");
  endtask

  task automatic test_enc_busy();
    logic seen;
    do_reset();
    enc_free = 1'b0; dat_pld = 88'h00FEEDFACE0000BEEF0001; dat_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt_v !== 3'b000) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_busy_nogrant: grant while enc_free=0 seen=%b, required 0", seen);
    end
    enc_free = 1'b1;
    tick(); // ISSUE
    n_chk++;
    if (gnt_v !== 3'b100 || pkt_type !== 2'b01 || data !== 88'h00FEEDFACE0000BEEF0001) begin
      n_fail++;
      $display("FAIL enc_free_grant: gnt=%b type=%b data=%h, required 100 01 00feedface0000beef0001",
               gnt_v, pkt_type, data);
    end
    dat_req = 1'b0;
    tick(); // BUSY
    pkt_sent = 1'b1;
    tick(); // DONE
    pkt_sent = 1'b0;
    n_chk++;
    if (done_v !== 3'b100 || tx_err !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_free_done: done=%b err=%b, required 100 0", done_v, tx_err);
    end
    $display("test_enc_busy done");
  endtask

  task automatic test_rst_busy();
    do_reset();
    hs_pld = 8'hC3; hs_req = 1'b1;
    tick(); // ISSUE
    n_chk++;
    if (hs_gnt !== 1'b1 || hshake !== 8'hC3) begin
      n_fail++;
      $display("FAIL rstb_gnt: hs_gnt=%b hs=%h, required 1 c3", hs_gnt, hshake);
    end
    hs_req = 1'b0;
    tick(); // BUSY
    rst = 1'b1;
    tick();
    n_chk++;
    if ({gnt_v, done_v, tx_err, pkt_type} !== 9'd0 || hshake !== 8'd0) begin
      n_fail++;
      $display("FAIL rstb_clear: gnt=%b done=%b err=%b type=%b hs=%h, required all 0",
               gnt_v, done_v, tx_err, pkt_type, hshake);
    end
    rst = 1'b0; pkt_sent = 1'b1; // stray pkt_sent in IDLE
    tick();
    pkt_sent = 1'b0;
    tick();
    n_chk++;
    if (done_v !== 3'b000 || tx_err !== 1'b0 || gnt_v !== 3'b000) begin
      n_fail++;
      $display("FAIL rstb_silent: done=%b err=%b gnt=%b, required 000 0 000", done_v, tx_err, gnt_v);
    end
    $display("test_rst_busy done");
  endtask

  initial begin
    hs_pld = '0; tok_pld = '0; dat_pld = '0;
    rst = 1'b1; hs_req = 1'b0; tok_req = 1'b0; dat_req = 1'b0;
    enc_free = 1'b0; pkt_sent = 1'b0;
    tick();
    test_reset();
    test_single_token();
    test_simultaneous();
    test_starvation();
    test_watchdog();
    test_sent_at_expiry();
    test_enc_busy();
    test_rst_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
